// File: rtl/stack_arbiter_pkg.sv
// Shared constants and FSM state type for the stack arbiter.
package stack_arbiter_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_DW    = 32;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_POP_WAIT,
    ST_REJECT
  } state_t;

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; remembers the last winner and favours the other port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] win
);

  logic last;

  always_comb begin
    win = req;
    if (req == 2'b11) win = last ? 2'b01 : 2'b10;
  end

  // last starts at 1 so port 0 wins the first contended grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last <= 1'b1;
    else if (update && |req)   last <= win[1];
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one hardware stack between the control unit (port 0) and datapath (port 1).
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          op0,
  input  logic          op1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          stk_read_en,
  output logic          stk_write_en,
  output logic [DW-1:0] stk_data_in,
  input  logic [DW-1:0] stk_data_out
);

  state_t     state, state_nxt;
  logic       sel;
  logic [1:0] req_v, win, sel_oh;
  logic       win_op, grant;

  assign req_v = {req1, req0};
  assign grant = (state == ST_IDLE) && |req_v;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_v),
    .update (grant),
    .win    (win)
  );

  assign win_op = win[1] ? op1 : op0;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (|req_v) begin
          if (win_op == OP_PUSH) state_nxt = full  ? ST_REJECT : ST_PUSH;
          else                   state_nxt = empty ? ST_REJECT : ST_POP;
        end
      end
      ST_POP:  state_nxt = ST_POP_WAIT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Every handshake output decodes from state and the captured winner only
  always_comb begin
    sel_oh       = sel ? 2'b10 : 2'b01;
    gnt          = '0;
    done         = '0;
    err          = 1'b0;
    stk_write_en = 1'b0;
    stk_read_en  = 1'b0;
    stk_data_in  = '0;
    rdata        = '0;
    if (state != ST_IDLE) gnt = sel_oh;
    case (state)
      ST_PUSH: begin
        stk_write_en = 1'b1;
        stk_data_in  = sel ? wdata1 : wdata0;
        done         = sel_oh;
      end
      ST_POP:  stk_read_en = 1'b1;
      ST_POP_WAIT: begin
        rdata = stk_data_out;
        done  = sel_oh;
      end
      ST_REJECT: begin
        done = sel_oh;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (grant) sel <= win[1];
      if (state == ST_PUSH)     count <= count + CW'(1);
      else if (state == ST_POP) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a LIFO reference model and completion scoreboard.
module tb_stack_arbiter;
  import stack_arbiter_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    op = '0;
  logic [DW-1:0] wdata [2] = '{32'h0, 32'h0};
  logic [1:0]    gnt, done;
  logic          err, full, empty, stk_read_en, stk_write_en;
  logic [DW-1:0] rdata, stk_data_in, stk_data_out;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  stack_arbiter #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req[0]),
    .req1         (req[1]),
    .op0          (op[0]),
    .op1          (op[1]),
    .wdata0       (wdata[0]),
    .wdata1       (wdata[1]),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .stk_read_en  (stk_read_en),
    .stk_write_en (stk_write_en),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out)
  );

  // behavioural stack: output registered one cycle after read_en
  logic [DW-1:0] smem [DEPTH];
  int            sp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp           <= 0;
      stk_data_out <= '0;
    end else if (stk_write_en && sp < DEPTH) begin
      smem[sp] <= stk_data_in;
      sp       <= sp + 1;
    end else if (stk_read_en && sp > 0) begin
      stk_data_out <= smem[sp-1];
      sp           <= sp - 1;
    end
  end

  typedef struct {
    int          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("%s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done != 2'b00) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("sb_done",  64'(done),  64'(2'b01 << e.port));
        chk("sb_err",   64'(err),   64'(e.err));
        chk("sb_rdata", 64'(rdata), 64'(e.rdata));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("rst_gnt",   64'(gnt), 64'(0));
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_en",    64'({stk_read_en, stk_write_en, err}), 64'(0));
    chk("rst_data",  64'({stk_data_in, rdata}), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'({empty, full}), 64'(2'b10));
    model.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called during an IDLE cycle; returns during the following IDLE cycle.
  task automatic run_op(input int p, input logic o, input logic [31:0] d,
                        output int lat, output logic err_s, output logic wen_s,
                        output logic ren_seen, output logic [31:0] din_s,
                        output logic [31:0] rd_s);
    exp_t e;
    e.port  = p;
    e.rdata = '0;
    if (o == OP_PUSH) begin
      e.err = (model.size() == DEPTH);
      if (!e.err) model.push_back(d);
    end else begin
      e.err = (model.size() == 0);
      if (!e.err) e.rdata = model.pop_back();
    end
    exp_q.push_back(e);
    req[p] = 1'b1; op[p] = o; wdata[p] = d;
    lat = 0; err_s = 0; wen_s = 0; ren_seen = 0; din_s = '0; rd_s = '0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (stk_read_en) ren_seen = 1'b1;
      if (done[p]) begin
        lat = k; err_s = err; wen_s = stk_write_en; din_s = stk_data_in; rd_s = rdata;
        break;
      end
    end
    req[p] = 1'b0;
    if (lat == 0) chk("op_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  int          lat;
  logic        e_s, w_s, r_s;
  logic [31:0] di_s, rd_s;
  logic [31:0] dv [4];
  int          got;

  initial begin
    do_reset();

    // port 0 push after reset
    run_op(0, OP_PUSH, 32'hDEADBEEF, lat, e_s, w_s, r_s, di_s, rd_s);
    chk("push_lat",   64'(lat), 64'(1));
    chk("push_wen",   64'(w_s), 64'(1));
    chk("push_din",   64'(di_s), 64'(32'hDEADBEEF));
    chk("push_count", 64'(count), 64'(1));
    chk("push_empty", 64'(empty), 64'(0));

    // LIFO ordering from port 1
    do_reset();
    run_op(1, OP_PUSH, 32'h11, lat, e_s, w_s, r_s, di_s, rd_s);
    run_op(1, OP_PUSH, 32'h22, lat, e_s, w_s, r_s, di_s, rd_s);
    run_op(1, OP_POP, 32'h0, lat, e_s, w_s, r_s, di_s, rd_s);
    chk("pop1_lat",   64'(lat), 64'(2));
    chk("pop1_rdata", 64'(rd_s), 64'(32'h22));
    chk("pop1_ren",   64'(r_s), 64'(1));
    run_op(1, OP_POP, 32'h0, lat, e_s, w_s, r_s, di_s, rd_s);
    chk("pop2_rdata", 64'(rd_s), 64'(32'h11));
    chk("pop2_count", 64'(count), 64'(0));

    // underflow
    run_op(0, OP_POP, 32'h0, lat, e_s, w_s, r_s, di_s, rd_s);
    chk("uflow_lat",   64'(lat), 64'(1));
    chk("uflow_err",   64'(e_s), 64'(1));
    chk("uflow_ren",   64'(r_s), 64'(0));
    chk("uflow_count", 64'(count), 64'(0));

    // overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      run_op(i % 2, OP_PUSH, 32'h100 + i, lat, e_s, w_s, r_s, di_s, rd_s);
    chk("fill_count", 64'(count), 64'(DEPTH));
    chk("fill_full",  64'(full), 64'(1));
    run_op(0, OP_PUSH, 32'h99, lat, e_s, w_s, r_s, di_s, rd_s);
    chk("oflow_err",   64'(e_s), 64'(1));
    chk("oflow_wen",   64'(w_s), 64'(0));
    chk("oflow_count", 64'(count), 64'(DEPTH));
    run_op(1, OP_POP, 32'h0, lat, e_s, w_s, r_s, di_s, rd_s);
    chk("full_pop_rdata", 64'(rd_s), 64'(32'h10F));

    // contention: both ports held for four pushes
    do_reset();
    dv = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back('{port: n % 2, err: 1'b0, rdata: 32'h0});
      model.push_back(dv[n]);
    end
    op = '0; wdata[0] = dv[0]; wdata[1] = dv[1]; req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      got = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (done != 2'b00) begin got = 1; break; end
      end
      if (got == 0) chk("rr_timeout", 64'(0), 64'(1));
      chk("rr_gnt", 64'(gnt), 64'((n % 2) ? 2'b10 : 2'b01));
      chk("rr_din", 64'(stk_data_in), 64'(dv[n]));
      if (gnt[0]) begin
        if (n == 0) wdata[0] = dv[2]; else req[0] = 1'b0;
      end else begin
        if (n == 1) wdata[1] = dv[3]; else req[1] = 1'b0;
      end
    end
    req = '0;
    @(posedge clk); #1;
    chk("rr_count", 64'(count), 64'(4));

    // reset during POP_WAIT
    do_reset();
    run_op(0, OP_PUSH, 32'h55, lat, e_s, w_s, r_s, di_s, rd_s);
    req[0] = 1'b1; op[0] = OP_POP;
    @(posedge clk); #1;
    chk("abort_ren", 64'(stk_read_en), 64'(1));
    @(posedge clk); #1;
    chk("abort_pre_done", 64'(done), 64'(2'b01));
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("abort_done",  64'(done), 64'(0));
    chk("abort_gnt",   64'(gnt), 64'(0));
    chk("abort_rdata", 64'(rdata), 64'(0));
    chk("abort_count", 64'(count), 64'(0));
    model.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, OP_PUSH, 32'h77, lat, e_s, w_s, r_s, di_s, rd_s);
    chk("post_lat",   64'(lat), 64'(1));
    chk("post_count", 64'(count), 64'(1));

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

- Shares the single 32-bit hardware stack between two requesters:
  - port 0: control unit, CALL/RET return addresses;
  - port 1: datapath, PUSH/POP instructions.
- Round-robin arbitration between the ports.
- Sequences the stack's `read_en`/`write_en` strobes and tracks occupancy.
- Rejects overflow/underflow with an error pulse instead of corrupting the stack.
- Sits between the control unit/datapath and the `stack` block; the only driver of the stack's enables.

## Interface
Parameters:
- `DEPTH`, 16, stack capacity in words; must equal the stack's depth.
- `DW`, 32, data width.
- `CW`, `$clog2(DEPTH+1)`, occupancy counter width.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0`, `req1` input 1: request; held high until that port's `done`.
- `op0`, `op1` input 1: 0 = push, 1 = pop; stable while `req` is high.
- `wdata0`, `wdata1` input DW: push data; stable while `req` is high.
- `gnt` output 2: one-hot, the port being served; high from the issue cycle through `done`.
- `done` output 2: one-cycle pulse per port; the operation completed or was rejected.
- `err` output 1: pulses with `done` when the operation was rejected (push when full, pop when empty).
- `rdata` output DW: pop result; valid only when `done` is high for a pop with `err` = 0.
- `count` output CW: current occupancy.
- `full`, `empty` output 1: `count == DEPTH` / `count == 0`.
- `stk_read_en`, `stk_write_en` output 1: enables to the stack.
- `stk_data_in` output DW: data to the stack.
- `stk_data_out` input DW: stack output, valid the cycle after `stk_read_en`.

## Operation
- FSM states: IDLE, PUSH, POP, POP_WAIT, REJECT.
- IDLE:
  - If any `req` is high, the arbiter picks a winner and registers `gnt`.
  - Next state:
    - PUSH if push and not `full`;
    - POP if pop and not `empty`;
    - REJECT otherwise.
- Arbitration is round-robin:
  - the winner is the requesting port other than `last`;
  - if only one port requests, it wins;
  - `last` updates to the winner on every grant, including rejects.
- PUSH: `stk_write_en` = 1, `stk_data_in` = the winner's `wdata`, `done` pulses, `count` += 1 at the end of the cycle; then IDLE.
- POP: `stk_read_en` = 1, `count` -= 1 at the end of the cycle; then POP_WAIT.
- POP_WAIT: `rdata` = `stk_data_out`, `done` pulses; then IDLE.
- REJECT:
  - no stack enable asserted, `count` unchanged;
  - `done` and `err` pulse; then IDLE.
- A requester must drop `req`, or present a new op, in the cycle after its `done`. A `req` still high in IDLE is treated as a new request.
- `stk_read_en` and `stk_write_en` are never high together. Never more than one op is in flight.
- `count` saturates logically: the reject path guarantees 0 ≤ `count` ≤ DEPTH.
- Reset:
  - `rst_n` low forces immediately: IDLE, `count` = 0, `last` = 1 (port 0 wins first);
  - `gnt`, `done`, `err`, `stk_read_en`, `stk_write_en` = 0; `stk_data_in`, `rdata` = 0.
- Reset mid-operation abandons the op with no `done`. The stack's own pointer shares `rst_n` at system level.

## Timing
- Cycle 0: `req` sampled in IDLE.
- Push:
  - cycle 1 is PUSH: `gnt`, `stk_write_en` and `done` are high together;
  - latency 1; throughput 1 push per 2 cycles.
- Pop:
  - cycle 1 is POP (`stk_read_en`), cycle 2 is POP_WAIT (`done`, `rdata` valid);
  - latency 2; throughput 1 pop per 3 cycles.
- Reject: cycle 1, `done` and `err` high; latency 1.
- `gnt`, `stk_*_en`, `done`, `err` are registered, or decoded from state only. `rdata` passes `stk_data_out` through combinationally during POP_WAIT and is 0 otherwise.
- Simultaneous `req0` and `req1`: one is served, and the other is served in the next IDLE. No starvation: worst-case wait is one foreign op.

## Structure
- `stack_arbiter_pkg` contains:
  - `OP_PUSH`/`OP_POP` constants;
  - the FSM state enum;
  - the default `DEPTH` and `DW`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter (`req[1:0]`, `last`, `update` → one-hot `win`), instantiated once.
- Top contains the FSM, occupancy counter, data muxes and the stack strobes.

## Test plan
- After reset, port 0 pushes 0xDEADBEEF: `stk_write_en` and `done[0]` high in cycle 1, `count` = 1, `empty` = 0.
- Push 0x11, then 0x22 from port 1, then pop: `rdata` = 0x22 with `done[1]` two cycles after issue; second pop returns 0x11; `count` back to 0.
- Pop on empty: `done` and `err` high in cycle 1, no `stk_read_en`, `count` stays 0.
- Fill to DEPTH = 16, then push 0x99: `full` = 1, `err` pulses, `stk_write_en` stays 0, `count` = 16.
- `req0` and `req1` held together for 4 pushes: grant order 0, 1, 0, 1; `stk_data_in` order matches; `count` = 4.
- Drop `rst_n` during POP_WAIT: outputs zero immediately, no `done`, `count` = 0; first request after release is served normally.
